// File: rtl/req_gnt_arbiter.sv
// Round-robin front end for a single req/gnt grant block: latches one client,
// requests downstream, forwards the grant for a bounded tenure, flags timeouts and lost grants.
//   state     | meaning
//   S_IDLE    | no request outstanding, arbitrating client requests
//   S_REQ     | req driven, waiting for gnt (bounded by TIMEOUT)
//   S_GRANT   | gnt held, winning client owns the grant
//   S_RELEASE | req dropped, waiting for downstream gnt to fall
module req_gnt_arbiter #(
  parameter int N_CLIENTS = 4,
  parameter int MAX_HOLD  = 8,
  parameter int TIMEOUT   = 15,
  parameter int CNT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_CLIENTS-1:0] client_req_i,
  output logic [N_CLIENTS-1:0] client_gnt_o,
  output logic                 req_o,
  input  logic                 gnt_i,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic                 gnt_lost_o,
  output logic [CNT_W-1:0]     grant_count_o
);

  localparam int SEL_W  = $clog2(N_CLIENTS);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(N_CLIENTS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [SEL_W:0]    N_WIDE    = (SEL_W + 1)'(N_CLIENTS);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GRANT, S_RELEASE} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic               lost_q, lost_d;

  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic [SEL_W-1:0]   sel_next;

  // First requesting client at or after ptr_q, wrapping past N_CLIENTS-1 back to 0.
  always_comb begin : rr_pick
    logic [SEL_W:0] sum;
    pick_found = 1'b0;
    pick_idx   = '0;
    sum        = '0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      sum = {1'b0, ptr_q} + (SEL_W + 1)'(k);
      if (sum >= N_WIDE) sum = sum - N_WIDE;
      if (!pick_found && client_req_i[sum[SEL_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = sum[SEL_W-1:0];
      end
    end
  end

  assign sel_next = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      ptr_q     <= '0;
      wait_q    <= '0;
      hold_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      wait_q    <= wait_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      lost_q    <= lost_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    wait_d    = wait_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    lost_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          wait_d  = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (gnt_i) begin
          hold_d  = '0;
          state_d = S_GRANT;
          if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          ptr_d     = sel_next;
          state_d   = S_RELEASE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_GRANT: begin
        if (!gnt_i) begin
          lost_d  = 1'b1;
          ptr_d   = sel_next;
          state_d = S_RELEASE;
        end else if (!client_req_i[sel_q] || (hold_q == HOLD_LAST)) begin
          ptr_d   = sel_next;
          state_d = S_RELEASE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!gnt_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_o         = (state_q == S_REQ) || (state_q == S_GRANT);
    busy_o        = (state_q != S_IDLE);
    client_gnt_o  = '0;
    if (state_q == S_GRANT) client_gnt_o[sel_q] = 1'b1;
    timeout_o     = timeout_q;
    gnt_lost_o    = lost_q;
    grant_count_o = cnt_q;
  end

endmodule

// File: tb/tb_req_gnt_arbiter.sv
// Bench for req_gnt_arbiter: directed scenarios with literal expectations, then random
// traffic against a tenure-age reference model, with a 1-cycle downstream grant block.
module tb_req_gnt_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int TIMEOUT  = 15;
  localparam int CNT_W    = 4;
  localparam int P_IDLE = 0, P_REQ = 1, P_GRANT = 2, P_REL = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     creq = '0;
  logic [N-1:0]     cgnt;
  logic             req, gnt, busy, tmo, lost;
  logic [CNT_W-1:0] gcnt;
  logic             dn_q = 1'b0;
  logic             force_low = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // downstream grant block: gnt follows req one clock later, can be forced low
  always @(posedge clk) dn_q <= req;
  assign gnt = dn_q & ~force_low;

  req_gnt_arbiter #(
    .N_CLIENTS(N), .MAX_HOLD(MAX_HOLD), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .client_req_i(creq), .client_gnt_o(cgnt),
    .req_o(req), .gnt_i(gnt), .busy_o(busy), .timeout_o(tmo),
    .gnt_lost_o(lost), .grant_count_o(gcnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: phase + age of the current phase in cycles
  int m_phase = P_IDLE, m_sel = 0, m_ptr = 0, m_age = 0, m_count = 0;
  bit m_tmo = 0, m_lost = 0;
  int m_pick;

  always @(posedge clk) begin
    m_tmo  = 0;
    m_lost = 0;
    if (rst) begin
      m_phase = P_IDLE; m_sel = 0; m_ptr = 0; m_age = 0; m_count = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (creq != 0) begin
          m_pick = -1;
          for (int k = 0; k < N; k++)
            if (m_pick < 0 && creq[(m_ptr + k) % N]) m_pick = (m_ptr + k) % N;
          m_sel = m_pick; m_phase = P_REQ; m_age = 1;
        end
        P_REQ: if (gnt) begin
          m_phase = P_GRANT; m_age = 1;
          if (m_count < (2 ** CNT_W) - 1) m_count++;
        end else if (m_age == TIMEOUT) begin
          m_tmo = 1; m_ptr = (m_sel + 1) % N; m_phase = P_REL;
        end else m_age++;
        P_GRANT: if (!gnt) begin
          m_lost = 1; m_ptr = (m_sel + 1) % N; m_phase = P_REL;
        end else if (!creq[m_sel] || m_age == MAX_HOLD) begin
          m_ptr = (m_sel + 1) % N; m_phase = P_REL;
        end else m_age++;
        default: if (!gnt) m_phase = P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    check("req", req, (m_phase == P_REQ || m_phase == P_GRANT));
    check("client_gnt", cgnt, (m_phase == P_GRANT) ? (1 << m_sel) : 0);
    check("busy", busy, (m_phase != P_IDLE));
    check("timeout", tmo, m_tmo);
    check("gnt_lost", lost, m_lost);
    check("grant_count", gcnt, m_count);
  end

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic wait_idle(input string name);
    int k = 0;
    while ((busy || gnt) && k < 50) begin @(negedge clk); k++; end
    check(name, (busy || gnt), 0);
  endtask

  task automatic wait_grant(input int limit, output logic [N-1:0] seen);
    int k = 0;
    while (cgnt == 0 && k < limit) begin @(negedge clk); k++; end
    seen = cgnt;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] seen;
    int k, n, nreq, n_g, stall;
    int order[5];
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    order     = '{-1, -1, -1, -1, -1};

    repeat (3) @(negedge clk);
    check("rst_req", req, 0);
    check("rst_cgnt", cgnt, 0);
    check("rst_busy", busy, 0);
    check("rst_count", gcnt, 0);
    check("rst_timeout", tmo, 0);
    check("rst_lost", lost, 0);

    // reset held for 3 cycles in the middle of a grant
    rst = 1'b0; creq = 4'b0001;
    wait_grant(20, seen);
    check("midgrant_reach", seen, 4'b0001);
    @(negedge clk);
    rst = 1'b1; creq = '0;
    repeat (3) @(negedge clk);
    check("midrst_req", req, 0);
    check("midrst_cgnt", cgnt, 0);
    check("midrst_busy", busy, 0);
    check("midrst_count", gcnt, 0);
    rst = 1'b0;
    wait_idle("midrst_idle");

    // single client held: latency, full tenure, re-arbitration
    creq = 4'b0010;
    @(negedge clk);
    check("single_req_rise", req, 1);
    @(negedge clk);
    check("single_gnt_early", cgnt, 0);
    @(negedge clk);
    check("single_gnt_latency", cgnt, 4'b0010);
    k = 0;
    while (cgnt == 4'b0010 && k < 30) begin k++; @(negedge clk); end
    check("single_tenure_len", k, MAX_HOLD);
    check("single_release_req", req, 0);
    wait_grant(20, seen);
    check("single_rearb", seen, 4'b0010);
    creq = '0;
    wait_idle("single_idle");

    // round robin with every client requesting, each releasing after one cycle
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    creq = 4'b1111; n_g = 0; k = 0;
    while (n_g < 5 && k < 100) begin
      @(negedge clk); k++;
      if (cgnt != 0) begin
        order[n_g] = onehot_idx(cgnt);
        n_g++;
        creq = 4'b1111 & ~cgnt;
        if (n_g == 5) check("rr_count", gcnt, 5);
      end else creq = 4'b1111;
    end
    creq = '0;
    check("rr_num_grants", n_g, 5);
    for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), order[i], exp_order[i]);
    wait_idle("rr_idle");

    // timeout: downstream never grants
    force_low = 1'b1; creq = 4'b0100; k = 0; nreq = 0;
    while (!tmo && k < 40) begin @(negedge clk); k++; if (req) nreq++; end
    check("tmo_seen", tmo, 1);
    check("tmo_req_cycles", nreq, TIMEOUT);
    check("tmo_req_drop", req, 0);
    force_low = 1'b0;
    @(negedge clk);
    check("tmo_single_pulse", tmo, 0);
    wait_grant(20, seen);
    check("tmo_next_client", seen, 4'b0100);
    creq = '0;
    wait_idle("tmo_idle");

    // lost grant on the third grant cycle
    creq = 4'b0001;
    wait_grant(20, seen);
    check("lost_reach", seen, 4'b0001);
    @(negedge clk);
    @(negedge clk);
    force_low = 1'b1;
    @(negedge clk);
    check("lost_pulse", lost, 1);
    check("lost_cgnt", cgnt, 0);
    check("lost_release_busy", busy, 1);
    creq = '0;
    @(negedge clk);
    check("lost_single_pulse", lost, 0);
    check("lost_idle", busy, 0);
    force_low = 1'b0;
    wait_idle("lost_settle");

    // withdrawal in the cycle gnt arrives
    creq = 4'b1000; k = 0;
    while (!gnt && k < 20) begin @(negedge clk); k++; end
    check("early_gnt_seen", gnt, 1);
    creq = '0; n = 0;
    repeat (8) begin @(negedge clk); if (cgnt == 4'b1000) n++; end
    check("early_grant_cycles", n, 1);
    wait_idle("early_idle");

    // random traffic
    stall = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 3) == 0) creq = 4'($urandom_range(0, 15));
      if (stall > 0) begin
        force_low = 1'b1; stall--;
      end else if ($urandom_range(0, 39) == 0) begin
        stall = $urandom_range(5, 25); force_low = 1'b1;
      end else force_low = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    rst = 1'b0; force_low = 1'b0; creq = '0;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
